// File: rtl/mem_port_arbiter_if.sv
// Request/grant/read-return bundle between requestors and the arbiter,
// plus the shared single-ported memory port it drives.
interface mem_port_arbiter_if #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
);
  logic [N_MASTERS-1:0]        req;
  logic [N_MASTERS-1:0]        req_wen;
  logic [N_MASTERS*ADDR_W-1:0] req_addr;
  logic [N_MASTERS*DATA_W-1:0] req_wdata;
  logic [N_MASTERS-1:0]        gnt;
  logic [N_MASTERS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        mem_en;
  logic                        mem_wen;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_din;
  logic [DATA_W-1:0]           mem_dout;

  modport slave (
    input  req, req_wen, req_addr, req_wdata, mem_dout,
    output gnt, rvalid, rdata, mem_en, mem_wen, mem_addr, mem_din
  );

  modport master (
    output req, req_wen, req_addr, req_wdata, mem_dout,
    input  gnt, rvalid, rdata, mem_en, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-master arbiter sharing one synchronous memory port; registers the winning
// access and returns read data to its issuer after RD_LATENCY cycles, in order.
module mem_port_arbiter #(
  parameter int unsigned N_MASTERS  = 3,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = 0
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] mem_idx;
  logic             tag_v   [RD_LATENCY];
  logic [IDX_W-1:0] tag_idx [RD_LATENCY];

  // Round-robin scans from last_grant+1; fixed priority scans from index 0.
  always_comb begin
    bus.gnt = '0;
    win     = '0;
    cand    = '0;
    found   = 1'b0;
    if (!reset) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        cand = (ARB_MODE != 0) ? IDX_W'(i)
                               : IDX_W'((32'(last_grant) + 32'd1 + i) % N_MASTERS);
        if (!found && bus.req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) bus.gnt[win] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant   <= IDX_W'(N_MASTERS - 1);
      bus.mem_en   <= 1'b0;
      bus.mem_wen  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      mem_idx      <= '0;
      for (int unsigned s = 0; s < RD_LATENCY; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      bus.mem_en  <= found;
      bus.mem_wen <= found & bus.req_wen[win];
      if (found) begin
        bus.mem_addr <= bus.req_addr[win*ADDR_W +: ADDR_W];
        bus.mem_din  <= bus.req_wdata[win*DATA_W +: DATA_W];
        mem_idx      <= win;
        if (ARB_MODE == 0) last_grant <= win;
      end
      // Tag pipeline tracks which master owns the read currently on the port.
      tag_v[0]   <= bus.mem_en & ~bus.mem_wen;
      tag_idx[0] <= mem_idx;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    if (tag_v[RD_LATENCY-1]) begin
      bus.rvalid[tag_idx[RD_LATENCY-1]] = 1'b1;
      bus.rdata                         = bus.mem_dout;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin/latency-2 and a fixed-priority/latency-1
// instance share stimulus and are checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int N     = 3;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int MAXC  = 8192;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.N_MASTERS(N), .ADDR_W(16), .DATA_W(16)) bus_a ();
  mem_port_arbiter_if #(.N_MASTERS(N), .ADDR_W(16), .DATA_W(16)) bus_b ();

  mem_port_arbiter #(.N_MASTERS(N), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(LAT_A), .ARB_MODE(0))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
  mem_port_arbiter #(.N_MASTERS(N), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(LAT_B), .ARB_MODE(1))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A3C;
  endfunction

  // Memory models: synchronous, written at the edge ending the access cycle.
  logic [15:0] mem_a [256];
  bit          wr_a  [256];
  logic [15:0] pipe_a [LAT_A];
  logic [15:0] mem_b [256];
  bit          wr_b  [256];
  logic [15:0] pipe_b [LAT_B];

  always @(posedge clock) begin
    if (bus_a.mem_en === 1'b1 && bus_a.mem_wen === 1'b1) begin
      mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_din;
      wr_a[bus_a.mem_addr[7:0]]  <= 1'b1;
    end
    pipe_a[0] <= wr_a[bus_a.mem_addr[7:0]] ? mem_a[bus_a.mem_addr[7:0]] : init_val(bus_a.mem_addr[7:0]);
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign bus_a.mem_dout = pipe_a[LAT_A-1];

  always @(posedge clock) begin
    if (bus_b.mem_en === 1'b1 && bus_b.mem_wen === 1'b1) begin
      mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_din;
      wr_b[bus_b.mem_addr[7:0]]  <= 1'b1;
    end
    pipe_b[0] <= wr_b[bus_b.mem_addr[7:0]] ? mem_b[bus_b.mem_addr[7:0]] : init_val(bus_b.mem_addr[7:0]);
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign bus_b.mem_dout = pipe_b[LAT_B-1];

  // Stimulus
  logic [2:0]  s_req, s_wen;
  logic [15:0] s_addr  [N];
  logic [15:0] s_wdata [N];

  // Reference model state (index 0 = round-robin instance, 1 = fixed priority)
  int          lg      [2];
  logic        e_en    [2];
  logic        e_wen   [2];
  logic [15:0] e_addr  [2];
  logic [15:0] e_din   [2];
  int          rsp_m   [2][MAXC];
  logic [15:0] rsp_d   [2][MAXC];
  logic [15:0] ref_mem [2][256];
  int          cyc;

  // Last observed values, for directed checks after a step
  logic [2:0]  o_g  [2];
  logic [2:0]  o_rv [2];
  logic        o_en [2];
  logic [15:0] o_addr [2];
  logic [15:0] o_rd [2];

  int checks;
  int errors;

  logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    bus_a.req       = s_req;
    bus_a.req_wen   = s_wen;
    bus_a.req_addr  = {s_addr[2], s_addr[1], s_addr[0]};
    bus_a.req_wdata = {s_wdata[2], s_wdata[1], s_wdata[0]};
    bus_b.req       = s_req;
    bus_b.req_wen   = s_wen;
    bus_b.req_addr  = {s_addr[2], s_addr[1], s_addr[0]};
    bus_b.req_wdata = {s_wdata[2], s_wdata[1], s_wdata[0]};
  endtask

  // Winner = requesting master with the smallest distance from the priority origin.
  function automatic int pick(input int k, input logic [2:0] r);
    int best  = -1;
    int bestd = N;
    if (reset) return -1;
    for (int m = 0; m < N; m++) begin
      if (r[m]) begin
        int d;
        d = (k == 1) ? m : (m - lg[k] - 1 + 2*N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = m;
        end
      end
    end
    return best;
  endfunction

  task automatic step();
    int w;
    int m;
    logic [7:0] a;
    @(negedge clock);
    o_g[0] = bus_a.gnt;    o_g[1] = bus_b.gnt;
    o_rv[0] = bus_a.rvalid; o_rv[1] = bus_b.rvalid;
    o_en[0] = bus_a.mem_en; o_en[1] = bus_b.mem_en;
    o_addr[0] = bus_a.mem_addr; o_addr[1] = bus_b.mem_addr;
    o_rd[0] = bus_a.rdata;  o_rd[1] = bus_b.rdata;
    for (int k = 0; k < 2; k++) begin
      w = pick(k, s_req);
      m = rsp_m[k][cyc];
      chk(k == 0 ? "gnt_a" : "gnt_b", 32'(o_g[k]), (w < 0) ? 32'd0 : (32'd1 << w));
      chk(k == 0 ? "en_a" : "en_b", 32'(o_en[k]), 32'(e_en[k]));
      chk(k == 0 ? "wen_a" : "wen_b", 32'(k == 0 ? bus_a.mem_wen : bus_b.mem_wen), 32'(e_wen[k]));
      chk(k == 0 ? "addr_a" : "addr_b", 32'(o_addr[k]), 32'(e_addr[k]));
      chk(k == 0 ? "din_a" : "din_b", 32'(k == 0 ? bus_a.mem_din : bus_b.mem_din), 32'(e_din[k]));
      chk(k == 0 ? "rvalid_a" : "rvalid_b", 32'(o_rv[k]), (m < 0) ? 32'd0 : (32'd1 << m));
      if (m >= 0) chk(k == 0 ? "rdata_a" : "rdata_b", 32'(o_rd[k]), 32'(rsp_d[k][cyc]));
      if (reset) begin
        lg[k] = N - 1;
        e_en[k] = 1'b0; e_wen[k] = 1'b0; e_addr[k] = '0; e_din[k] = '0;
        for (int c = cyc + 1; c < cyc + 8; c++) rsp_m[k][c] = -1;
      end else if (w >= 0) begin
        a = s_addr[w][7:0];
        e_en[k] = 1'b1; e_wen[k] = s_wen[w]; e_addr[k] = s_addr[w]; e_din[k] = s_wdata[w];
        if (k == 0) lg[k] = w;
        if (s_wen[w]) ref_mem[k][a] = s_wdata[w];
        else begin
          rsp_m[k][cyc + 1 + (k == 0 ? LAT_A : LAT_B)] = w;
          rsp_d[k][cyc + 1 + (k == 0 ? LAT_A : LAT_B)] = ref_mem[k][a];
        end
      end else begin
        e_en[k] = 1'b0; e_wen[k] = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      lg[k] = N - 1;
      e_en[k] = 1'b0; e_wen[k] = 1'b0; e_addr[k] = '0; e_din[k] = '0;
      for (int c = 0; c < MAXC; c++) rsp_m[k][c] = -1;
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_val(8'(a));
    end
    reset = 1'b1; s_req = '0; s_wen = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = 16'h0100 + 16'(i);
      s_wdata[i] = '0;
    end
    drive();
    @(posedge clock);
    #1;

    // Reset held two cycles with all masters requesting
    s_req = 3'b111; drive();
    step(); step();
    reset = 1'b0;

    // Round-robin fairness, master 0 first after reset
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_order", 32'(o_g[0]), 32'(rr_exp[i]));
    end
    s_req = '0; drive();
    repeat (3) step();

    // Write 0xBEEF, then master 1 reads it back
    s_req = 3'b001; s_wen = 3'b001; s_addr[0] = 16'h0040; s_wdata[0] = 16'hBEEF; drive();
    step();
    s_req = 3'b010; s_wen = 3'b000; s_addr[1] = 16'h0040; drive();
    step();
    s_req = '0; drive();
    step();
    chk("rd_en", 32'(o_en[0]), 32'd1);
    chk("rd_addr", 32'(o_addr[0]), 32'h0040);
    step(); step();
    chk("rd_rvalid", 32'(o_rv[0]), 32'b010);
    chk("rd_rdata", 32'(o_rd[0]), 32'hBEEF);

    // Fixed priority starvation and release
    s_req = 3'b110; s_addr[1] = 16'h0031; s_addr[2] = 16'h0032; drive();
    repeat (4) begin
      step();
      chk("fp_hold", 32'(o_g[1]), 32'b010);
    end
    s_req = 3'b100; drive();
    step();
    chk("fp_next", 32'(o_g[1]), 32'b100);
    s_req = '0; drive();
    repeat (3) step();

    // Back-to-back write then read of the same address
    s_req = 3'b001; s_wen = 3'b001; s_addr[0] = 16'h0010; s_wdata[0] = 16'h1234; drive();
    step();
    s_req = 3'b100; s_wen = 3'b000; s_addr[2] = 16'h0010; drive();
    step();
    s_req = '0; drive();
    step(); step();
    chk("b2b_rv_b", 32'(o_rv[1]), 32'b100);
    chk("b2b_rd_b", 32'(o_rd[1]), 32'h1234);
    step();
    chk("b2b_rv_a", 32'(o_rv[0]), 32'b100);
    chk("b2b_rd_a", 32'(o_rd[0]), 32'h1234);

    // Reset while a read is in flight
    s_req = 3'b010; s_addr[1] = 16'h0020; drive();
    step();
    reset = 1'b1; s_req = '0; drive();
    step();
    reset = 1'b0;
    step();
    chk("rst_en_a", 32'(o_en[0]), 32'd0);
    chk("rst_en_b", 32'(o_en[1]), 32'd0);
    repeat (3) begin
      step();
      chk("rst_rv_a", 32'(o_rv[0]), 32'd0);
      chk("rst_rv_b", 32'(o_rv[1]), 32'd0);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      s_req = 3'($urandom);
      s_wen = 3'($urandom);
      for (int m = 0; m < N; m++) begin
        s_addr[m]  = 16'($urandom) & 16'hF01F;
        s_wdata[m] = 16'($urandom);
      end
      drive();
      step();
    end
    reset = 1'b0; s_req = '0; drive();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
